// File: rtl/uart_rx.sv
// UART receiver: start / 8 data bits LSB first / optional parity / stop,
// PRESCALE clocks per bit, each bit decided by a 2-of-3 majority around mid-bit.
module uart_rx #(
    parameter int PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       Data_Valid,
    output logic       par_err,
    output logic       stp_err,
    output logic       busy,
    output logic [2:0] dbg_state_o
);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] SMP_0 = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] SMP_1 = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] SMP_2 = CW'(PRESCALE / 2 + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   edge_cnt_q, edge_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      samp_q, samp_d;
    logic            par_en_q, par_en_d;
    logic            par_typ_q, par_typ_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      p_data_q, p_data_d;
    logic            dv_q, dv_d;
    logic            par_err_q, par_err_d;
    logic            stp_err_q, stp_err_d;
    logic            busy_q, busy_d;
    logic            maj;

    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        samp_d      = samp_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        frame_err_d = frame_err_q;
        p_data_d    = p_data_q;
        dv_d        = 1'b0;
        par_err_d   = 1'b0;
        stp_err_d   = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = (edge_cnt_q == LAST) ? '0 : edge_cnt_q + CW'(1);
            if (edge_cnt_q == SMP_0) samp_d[0] = RX_IN;
            if (edge_cnt_q == SMP_1) samp_d[1] = RX_IN;
            if (edge_cnt_q == SMP_2) samp_d[2] = RX_IN;
        end

        case (state_q)
            IDLE: begin
                // The detecting cycle is edge 0 of the start bit, so START begins at edge 1.
                if (!RX_IN) begin
                    state_d     = START;
                    edge_cnt_d  = CW'(1);
                    bit_cnt_d   = '0;
                    par_en_d    = PAR_EN;
                    par_typ_d   = PAR_TYP;
                    frame_err_d = 1'b0;
                end
            end
            START: begin
                if (edge_cnt_q == LAST) begin
                    state_d   = maj ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (edge_cnt_q == LAST) begin
                    shreg_d[bit_cnt_q] = maj;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (edge_cnt_q == LAST) begin
                    if (maj != (^shreg_q ^ par_typ_q)) begin
                        par_err_d   = 1'b1;
                        frame_err_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (edge_cnt_q == LAST) begin
                    if (!maj) begin
                        stp_err_d = 1'b1;
                    end else if (!frame_err_q) begin
                        p_data_d = shreg_q;
                        dv_d     = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            edge_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            samp_q      <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            frame_err_q <= 1'b0;
            p_data_q    <= '0;
            dv_q        <= 1'b0;
            par_err_q   <= 1'b0;
            stp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_cnt_q  <= edge_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            samp_q      <= samp_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            frame_err_q <= frame_err_d;
            p_data_q    <= p_data_d;
            dv_q        <= dv_d;
            par_err_q   <= par_err_d;
            stp_err_q   <= stp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign P_DATA      = p_data_q;
    assign Data_Valid  = dv_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit, and every expected
// output pulse (kind, data, cycle) is queued when the frame is driven.
module tb_uart_rx;
    localparam int P = 8;

    logic       clk;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;
    logic [2:0] dbg_state_o;

    uart_rx #(.PRESCALE(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy),
        .dbg_state_o (dbg_state_o)
    );

    // Pulse code: {Data_Valid, par_err, stp_err, data-if-valid}
    localparam int W = 11;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    logic [7:0]   exp_pdata = 8'h00;
    logic [W-1:0] obs;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pdata"}, 32'(P_DATA), 32'h0);
        check({tag, "_dv"},    32'(Data_Valid), 32'h0);
        check({tag, "_perr"},  32'(par_err), 32'h0);
        check({tag, "_serr"},  32'(stp_err), 32'h0);
        check({tag, "_busy"},  32'(busy), 32'h0);
        check({tag, "_state"}, 32'(dbg_state_o), 32'h0);
    endtask

    // Drives one frame. flip_par inverts the parity bit, gl_idx/gl_edge inverts one
    // cycle of one frame bit, rst_idx pulses reset at edge 2 of that frame bit and aborts.
    task automatic send_frame(input logic [7:0] data, input logic pen, input logic ptyp,
                              input logic flip_par, input logic stop_bit,
                              input int gl_idx, input int gl_edge, input int rst_idx);
        logic bits [11];
        int   nbits;
        int   t0;
        logic perr;
        nbits = pen ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        perr = pen && flip_par;
        if (pen) bits[9] = (^data) ^ ptyp ^ flip_par;
        bits[nbits-1] = stop_bit;
        t0 = cyc;
        if (rst_idx < 0) begin
            if (perr) begin
                exp_q.push_back({3'b010, 8'h00});
                exp_cyc_q.push_back(t0 + 10 * P);
            end
            if (!stop_bit) begin
                exp_q.push_back({3'b001, 8'h00});
                exp_cyc_q.push_back(t0 + nbits * P);
            end else if (!perr) begin
                exp_q.push_back({3'b100, data});
                exp_cyc_q.push_back(t0 + nbits * P);
                exp_pdata = data;
            end
        end
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        for (int b = 0; b < nbits; b++) begin
            for (int e = 0; e < P; e++) begin
                RX_IN = bits[b] ^ ((b == gl_idx) && (e == gl_edge));
                if (b == rst_idx && e == 2) begin
                    rst = 1'b0;
                    tick();
                    rst   = 1'b1;
                    RX_IN = 1'b1;
                    exp_pdata = 8'h00;
                    check_all_zero("midframe_rst");
                    return;
                end
                tick();
                if (b == 0 && e == 0) begin
                    PAR_EN  = 1'($urandom_range(0, 1));
                    PAR_TYP = 1'($urandom_range(0, 1));
                end
            end
        end
        RX_IN = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && (Data_Valid || par_err || stp_err)) begin
            obs = {Data_Valid, par_err, stp_err, (Data_Valid ? P_DATA : 8'h00)};
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(obs), 32'h0);
            end else begin
                check("pulse_kind_data", 32'(obs), 32'(exp_q.pop_front()));
                check("pulse_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
            end
        end
    end

    initial begin
        int t0;
        rst     = 1'b0;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        idle(4);

        // 0xA5, no parity: Data_Valid at cycle 80
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
        idle(2 * P);
        check("pdata_a5", 32'(P_DATA), 32'h0A5);

        // 0x3C, even parity: good, then parity bit forced wrong
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, -1);
        idle(2 * P);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, -1);
        idle(2 * P);
        check("pdata_hold_par", 32'(P_DATA), 32'h03C);

        // 0x55 with stop bit 0
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1);
        idle(2 * P);
        check("pdata_hold_stop", 32'(P_DATA), 32'h03C);

        // Start glitch: low 2 cycles, back to IDLE at cycle 8
        t0 = cyc;
        RX_IN = 1'b0;
        repeat (2) tick();
        RX_IN = 1'b1;
        repeat (5) tick();
        check("glitch_busy_c7", 32'(busy), 32'h1);
        check("glitch_cycle", 32'(cyc - t0), 32'd7);
        tick();
        check("glitch_busy_c8", 32'(busy), 32'h0);
        check("glitch_state_c8", 32'(dbg_state_o), 32'h0);
        idle(P);

        // 0x01 with one inverted cycle at edge 4 of data bit 3
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4, -1);
        idle(2 * P);
        check("pdata_01", 32'(P_DATA), 32'h001);

        // Back-to-back 0x00, 0xFF with odd parity
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, -1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, -1);
        idle(2 * P);
        check("pdata_ff", 32'(P_DATA), 32'h0FF);

        // Reset during data bit 4, then 0x81
        send_frame(8'h3A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 5);
        idle(3 * P);
        check("post_rst_pdata", 32'(P_DATA), 32'h000);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
        idle(2 * P);
        check("pdata_81", 32'(P_DATA), 32'h081);

        // Random valid frames, some back-to-back, each with one inverted data cycle
        for (int k = 0; k < 8; k++) begin
            send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b0, 1'b1,
                       $urandom_range(1, 8), $urandom_range(0, P - 1), -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2 * P));
        end
        idle(2 * P);
        check("pdata_final", 32'(P_DATA), 32'(exp_pdata));
        check("pending_expected", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: PRESCALE, default 8, clk cycles per UART bit; SHALL be even and >= 6.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port: RX_IN  input  1  serial line from uart_tx TX_out; idle high; same clock domain, no synchronizer.
REQ-005 Port: PAR_EN  input  1  1 = frame carries a parity bit between data and stop.
REQ-006 Port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 Port: P_DATA  output  8  last correctly received byte.
REQ-008 Port: Data_Valid  output  1  one-cycle pulse; P_DATA is new and error-free.
REQ-009 Port: par_err  output  1  one-cycle pulse on parity mismatch.
REQ-010 Port: stp_err  output  1  one-cycle pulse when the stop bit samples 0.
REQ-011 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 Frame format SHALL be: start(0), 8 data bits LSB first, optional parity, stop(1). This matches uart_tx.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE, RX_IN=0 SHALL move the FSM to START. That cycle counts as edge_cnt=0. PAR_EN and PAR_TYP SHALL be latched in the same cycle.
REQ-015 Changes on PAR_EN or PAR_TYP during a frame SHALL be ignored until the next start detection.
REQ-016 edge_cnt SHALL count 0..PRESCALE-1 within each bit and wrap to 0 at the bit boundary.
REQ-017 Each bit SHALL be captured at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The bit value SHALL be the 2-of-3 majority of those samples.
REQ-018 Bit decisions and state transitions SHALL occur at edge_cnt = PRESCALE-1.
REQ-019 START: if the sampled bit is 1 (glitch), the FSM SHALL return to IDLE with no output pulse. Otherwise it SHALL go to DATA.
REQ-020 DATA: bit_cnt 0..7 SHALL shift the sampled bit into a shift-register at position bit_cnt.
REQ-021 After bit 7, the FSM SHALL go to PARITY if the latched PAR_EN=1, else to STOP.
REQ-022 PARITY: expected bit = XOR(data) for even, ~XOR(data) for odd. On mismatch, par_err SHALL pulse for 1 cycle and an internal frame-error flag SHALL be set. The FSM SHALL then go to STOP.
REQ-023 STOP: if the sample is 0, stp_err SHALL pulse for 1 cycle.
REQ-024 STOP: if the sample is 1 and no parity error occurred, P_DATA SHALL load the shift-register and Data_Valid SHALL pulse for 1 cycle.
REQ-025 STOP: the FSM SHALL go to IDLE in all cases.
REQ-026 On any frame error, P_DATA SHALL hold its previous value and Data_Valid SHALL stay 0.
REQ-027 All outputs SHALL be registered. Pulses SHALL be high in the cycle after the deciding edge_cnt=PRESCALE-1 cycle.
REQ-028 Latency: with cycle 0 the first cycle RX_IN=0 in IDLE, Data_Valid SHALL be high in cycle 10*PRESCALE (no parity) or 11*PRESCALE (parity).
REQ-029 A start bit beginning in the cycle immediately after the stop bit ends (back-to-back frames) SHALL be detected with no lost cycle.
REQ-030 A single-cycle inverted sample inside any bit SHALL NOT change the decided bit value.

Reset
REQ-031 rst=0 at a rising edge SHALL force: state IDLE, edge_cnt=0, bit_cnt=0, shift-register 0x00, P_DATA=0x00, Data_Valid=0, par_err=0, stp_err=0, busy=0.
REQ-032 Reset SHALL take priority over all other behaviour in every state, including mid-frame.
REQ-033 After reset, a partial frame SHALL produce no output pulse.
REQ-034 After rst returns to 1, the first RX_IN=0 SHALL be treated as a start bit.

Verification
REQ-035 PRESCALE=8, PAR_EN=0, uart_tx loopback of 0xA5 -> Data_Valid pulse in cycle 80, P_DATA=0xA5, par_err=stp_err=0.
REQ-036 PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0 -> P_DATA=0x3C, Data_Valid in cycle 88.
REQ-036a Repeat REQ-036 with the parity bit forced to 1 -> par_err pulse in cycle 80, no Data_Valid, P_DATA remains 0x3C.
REQ-037 0x55 with the stop bit driven 0 -> stp_err pulse in cycle 80, no Data_Valid, P_DATA unchanged.
REQ-038 RX_IN low 2 cycles then high -> FSM returns to IDLE at cycle 8 with no pulses.
REQ-038a Then send 0x01 with one inverted cycle at edge_cnt=4 of bit 3 -> P_DATA=0x01, Data_Valid pulse.
REQ-039 Back-to-back frames 0x00 then 0xFF, PAR_EN=1, PAR_TYP=1 -> two Data_Valid pulses exactly 88 cycles apart; P_DATA 0x00 then 0xFF; no errors.
REQ-040 rst=0 for one cycle during DATA bit 4 -> next cycle all outputs 0 and busy=0.
REQ-040a After that reset, a following frame 0x81 -> received correctly, Data_Valid pulse, P_DATA=0x81.
